// File: rtl/plot_arbiter_pkg.sv
// Shared widths, colour constants and FSM encoding for the VGA plot-port arbiter.
package plot_arbiter_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;
  localparam int BURST_W  = 20;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK      = 3'b000;
  localparam logic [BURST_W-1:0]  MAX_BURST_DEFAULT = 20'd4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational requester pick: lane N-1 always wins, otherwise round-robin over
// lanes 0..N-2 starting just after the last granted lane.
module plot_arbiter_rr_pick #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [N-1:0] elig;
  int           start;
  int           j;

  assign elig = req & ~mask;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    // last = N-1 (reset value) restarts the search at lane 0
    start = (int'(last) >= N - 2) ? 0 : int'(last) + 1;
    if (elig[N-1]) begin
      pick[N-1] = 1'b1;
      idx       = IW'(N - 1);
      valid     = 1'b1;
    end else begin
      for (int off = 0; off < N - 1; off++) begin
        j = start + off;
        if (j >= N - 1) j = j - (N - 1);
        if (!valid && elig[j]) begin
          pick[j] = 1'b1;
          idx     = IW'(j);
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the VGA plot port between drawing engines: one burst at a time, priority
// lane N-1, registered plot bus, erase substitution and burst-length watchdog.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int                 N         = 5,
  parameter logic [BURST_W-1:0] MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N-1:0]          req,
  input  logic [COORD_W*N-1:0]  pix_x,
  input  logic [COORD_W*N-1:0]  pix_y,
  input  logic [COLOUR_W*N-1:0] pix_colour,
  input  logic [N-1:0]          pix_we,
  input  logic                  erase,
  output logic [N-1:0]          grant,
  output logic                  busy,
  output logic [COORD_W-1:0]    x,
  output logic [COORD_W-1:0]    y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  writeEn,
  output logic                  timeout_err
);

  localparam int IW = $clog2(N);

  arb_state_t           state_reg, state_next;
  logic [N-1:0]         req_q;
  logic [N-1:0]         grant_reg;
  logic [N-1:0]         mask_reg, mask_next;
  logic [IW-1:0]        last_reg;
  logic [BURST_W-1:0]   cnt_reg;
  logic [COORD_W-1:0]   x_reg, y_reg;
  logic [COLOUR_W-1:0]  colour_reg;
  logic                 we_reg;
  logic                 timeout_err_reg;
  logic                 timeout_hit;
  logic                 req_g;

  logic [N-1:0]         pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  logic [COORD_W-1:0]   x_arr   [N];
  logic [COORD_W-1:0]   y_arr   [N];
  logic [COLOUR_W-1:0]  col_arr [N];
  logic [COORD_W-1:0]   x_sel, y_sel;
  logic [COLOUR_W-1:0]  col_sel;
  logic                 we_sel;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign x_arr[gi]   = pix_x[gi*COORD_W +: COORD_W];
      assign y_arr[gi]   = pix_y[gi*COORD_W +: COORD_W];
      assign col_arr[gi] = pix_colour[gi*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  always_comb begin
    x_sel   = '0;
    y_sel   = '0;
    col_sel = '0;
    we_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_reg[i]) begin
        x_sel   |= x_arr[i];
        y_sel   |= y_arr[i];
        col_sel |= col_arr[i];
        we_sel  |= pix_we[i];
      end
    end
  end

  plot_arbiter_rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req   (req_q),
    .last  (last_reg),
    .mask  (mask_reg),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign req_g = |(req_q & grant_reg);

  // A timed-out lane stays masked until its registered request is seen low.
  assign mask_next = (mask_reg & req_q) | (timeout_hit ? grant_reg : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      req_q           <= '0;
      grant_reg       <= '0;
      mask_reg        <= '0;
      last_reg        <= IW'(N - 1);
      cnt_reg         <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      colour_reg      <= '0;
      we_reg          <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_q     <= req;
      mask_reg  <= mask_next;
      if (state_reg == ST_IDLE && pick_valid) begin
        grant_reg <= pick;
        cnt_reg   <= '0;
        if (!pick[N-1]) last_reg <= pick_idx;
      end else if (state_reg == ST_GRANT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == ST_GRANT) begin
        x_reg      <= x_sel;
        y_reg      <= y_sel;
        colour_reg <= (erase && !grant_reg[N-1]) ? COLOUR_BLACK : col_sel;
        we_reg     <= we_sel;
      end else begin
        we_reg     <= 1'b0;
      end
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE:  if (pick_valid) state_next = ST_GRANT;
      ST_GRANT: begin
        if (!req_g) begin
          state_next = ST_GAP;
        end else if (cnt_reg == MAX_BURST - 1'b1) begin
          state_next  = ST_GAP;
          timeout_hit = 1'b1;
        end
      end
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant       = (state_reg == ST_GRANT) ? grant_reg : '0;
    busy        = (state_reg == ST_GRANT);
    x           = x_reg;
    y           = y_reg;
    colour      = colour_reg;
    writeEn     = we_reg;
    timeout_err = timeout_err_reg;
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: single burst, round-robin, priority,
// erase, burst timeout and reset mid-burst, all with hand-computed expectations.
module tb_plot_arbiter;

  localparam int N = 5;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [10*N-1:0] pix_x = '0;
  logic [10*N-1:0] pix_y = '0;
  logic [3*N-1:0]  pix_colour = '0;
  logic [N-1:0]    pix_we = '0;
  logic            erase = 1'b0;
  logic [N-1:0]    grant;
  logic            busy;
  logic [9:0]      x;
  logic [9:0]      y;
  logic [2:0]      colour;
  logic            writeEn;
  logic            timeout_err;

  int checks = 0;
  int failures = 0;

  plot_arbiter #(.N(N), .MAX_BURST(20'd8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
    .pix_we      (pix_we),
    .erase       (erase),
    .grant       (grant),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .writeEn     (writeEn),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pix(input int i, input int px, input int py, input int pc, input int pw);
    pix_x[i*10 +: 10]    = 10'(px);
    pix_y[i*10 +: 10]    = 10'(py);
    pix_colour[i*3 +: 3] = 3'(pc);
    pix_we[i]            = (pw != 0);
  endtask

  // Waits (bounded) for the current grant to end, then for the next one.
  task automatic wait_grant(input string tag, input int exp);
    int n;
    n = 0;
    while (grant != '0 && n < 30) begin tick(); n++; end
    n = 0;
    while (grant == '0 && n < 30) begin tick(); n++; end
    check_val(tag, int'(grant), exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (grant != '0 && n < 30) begin tick(); n++; end
    check_val(tag, int'(grant), 0);
  endtask

  int exp_g [1:8] = '{0, 2, 2, 2, 2, 0, 0, 0};
  int exp_w [1:8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int rr_exp [4]  = '{1, 2, 4, 1};
  int rr_idx [4]  = '{0, 1, 2, 0};

  initial begin
    int cnt;
    int n;

    // reset state
    tick();
    check_val("rst_grant", int'(grant), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_x", int'(x), 0);
    check_val("rst_we", int'(writeEn), 0);
    check_val("rst_terr", int'(timeout_err), 0);
    resetn = 1'b1;
    tick();
    tick();

    // single requester, 4-cycle burst
    set_pix(1, 10, 20, 5, 1);
    req[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_val($sformatf("single_grant_c%0d", i), int'(grant), exp_g[i]);
      check_val($sformatf("single_we_c%0d", i), int'(writeEn), exp_w[i]);
      if (i == 3) begin
        check_val("single_x", int'(x), 10);
        check_val("single_y", int'(y), 20);
        check_val("single_col", int'(colour), 5);
      end
      if (i == 4) req[1] = 1'b0;
    end
    set_pix(1, 0, 0, 0, 0);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // round-robin 0,1,2,0
    req[2:0] = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr_grant%0d", k), rr_exp[k]);
      tick();
      tick();
      if (k == 3) req = '0;
      else req[rr_idx[k]] = 1'b0;
      tick();
      if (k < 3) req[rr_idx[k]] = 1'b1;
    end
    wait_idle("rr_idle");

    // priority lane and no preemption
    req = 5'b10001;
    wait_grant("prio_first", 16);
    tick();
    tick();
    req[4] = 1'b0;
    wait_grant("prio_then0", 1);
    tick();
    req[4] = 1'b1;
    tick();
    tick();
    tick();
    check_val("no_preempt", int'(grant), 1);
    req[0] = 1'b0;
    wait_grant("prio_after_gap", 16);
    req[4] = 1'b0;
    wait_idle("prio_idle");

    // erase substitution, lane 4 exempt
    erase = 1'b1;
    set_pix(2, 5, 6, 7, 1);
    req[2] = 1'b1;
    wait_grant("erase_g2", 4);
    tick();
    check_val("erase_we2", int'(writeEn), 1);
    check_val("erase_col2", int'(colour), 0);
    req[2] = 1'b0;
    set_pix(4, 7, 8, 7, 1);
    req[4] = 1'b1;
    wait_grant("erase_g4", 16);
    tick();
    check_val("erase_col4", int'(colour), 7);
    req[4] = 1'b0;
    wait_idle("erase_idle");
    erase = 1'b0;

    // burst timeout with MAX_BURST=8
    check_val("to_pre_terr", int'(timeout_err), 0);
    set_pix(3, 1, 2, 3, 1);
    req[3] = 1'b1;
    wait_grant("to_grant", 8);
    cnt = 1;
    n = 0;
    while (grant != '0 && n < 30) begin
      tick();
      if (grant != '0) cnt++;
      n++;
    end
    check_val("to_len", cnt, 8);
    check_val("to_terr", int'(timeout_err), 1);
    repeat (6) tick();
    check_val("to_masked", int'(grant), 0);
    req[3] = 1'b0;
    tick();
    req[3] = 1'b1;
    wait_grant("to_regrant", 8);
    tick();
    req[3] = 1'b0;
    wait_idle("to_idle");

    // asynchronous reset mid-burst
    req[2] = 1'b1;
    wait_grant("rm_g2", 4);
    req[1] = 1'b1;
    req[3] = 1'b1;
    tick();
    check_val("rm_we_pre", int'(writeEn), 1);
    #2 resetn = 1'b0;
    #1;
    check_val("rm_grant", int'(grant), 0);
    check_val("rm_busy", int'(busy), 0);
    check_val("rm_we", int'(writeEn), 0);
    check_val("rm_terr", int'(timeout_err), 0);
    check_val("rm_x", int'(x), 0);
    tick();
    resetn = 1'b1;
    wait_grant("rm_first", 2);
    req = '0;
    wait_idle("rm_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single VGA pixel-plot port between the drawing engines (ball, brick, platform, loader, full-screen picture). Each engine requests the port, draws a burst of pixels while granted, then releases it. The arbiter selects one requester at a time, round-robin with one priority lane, and registers the winner's pixel onto the plot bus. It applies the erase (black) substitution and aborts any burst that overruns a cycle budget.

## Interface
- `N`, default 5: number of requesters. Index `N-1` is the priority lane (screen picture).
- `MAX_BURST`, default 20'd4096: maximum grant length in cycles before a forced release.
- `clk` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-low reset.
- `req` in N: level request per engine. Held high for the whole burst.
- `pix_x` in 10*N: per-requester x coordinates, packed, requester i at [10i+9:10i].
- `pix_y` in 10*N: per-requester y coordinates, packed the same way.
- `pix_colour` in 3*N: per-requester colour, packed.
- `pix_we` in N: per-requester pixel write strobe.
- `erase` in 1: when high, every plotted colour is forced to 3'b000. Requester N-1 is exempt.
- `grant` out N: one-hot grant, or all zeros.
- `busy` out 1: high while any grant is active.
- `x` out 10: registered plot x.
- `y` out 10: registered plot y.
- `colour` out 3: registered plot colour.
- `writeEn` out 1: registered plot strobe.
- `timeout_err` out 1: sticky flag. Set when a burst is forced off. Cleared only by reset.

## Operation
- Reset values: `grant`=0, `busy`=0, `x`=0, `y`=0, `colour`=0, `writeEn`=0, `timeout_err`=0, round-robin pointer `last`=N-1, state IDLE.
- State IDLE:
  - If `req[N-1]`=1, grant N-1.
  - Otherwise grant the first set bit of `req[N-2:0]`, searching upward from `last+1` and wrapping modulo N-1.
  - If no request is set, stay in IDLE.
  - On a grant: go to state GRANT, latch the index `g`, set `last`=`g` (only when `g`≠N-1), clear the burst counter.
- State GRANT:
  - Burst counter increments every cycle.
  - `x`/`y`/`colour`/`writeEn` are loaded from `pix_*[g]` each cycle.
  - If `erase`=1 and `g`≠N-1, `colour` is 3'b000.
  - If `req[g]`=0, go to GAP.
  - Else if the counter reaches MAX_BURST-1, set `timeout_err`, go to GAP.
- State GAP:
  - `grant`=0 and `writeEn`=0 for exactly one cycle, then IDLE.
  - During GAP a timed-out requester must drop `req` before it can be regranted. A timed-out requester whose `req` is still high at IDLE is masked until its `req` has been seen low for at least one cycle.
- `writeEn` is forced to 0 outside GRANT.
- `x`, `y` and `colour` hold their last values outside GRANT.
- No preemption: a priority request arriving mid-burst waits for the current burst to release.
- Simultaneous release by `g` and a new request from the same requester: the GAP cycle is still inserted, and round-robin then favours the other requesters.
- Changes to `req` bits other than `g` during GRANT are ignored.
- Reset mid-burst: all outputs return to reset values asynchronously; the in-flight burst is dropped with no completion signal.

## Timing
- Request to grant: the `req` rising edge is sampled at edge k; `grant` is high after edge k+1 (from IDLE).
- Grant to first plot: a pixel presented with `pix_we` during cycle c appears on `x`/`y`/`colour`/`writeEn` after the next edge (1-cycle latency).
- Release: `req[g]` low at edge k → `grant` low after edge k+1 → IDLE at k+2 → an earliest new grant after k+3.
- Because of the output register, the pixel presented in the cycle `req` drops is still plotted if its `pix_we` is high.
- Burst counter is 20 bits and does not wrap: timeout fires at exactly MAX_BURST cycles of GRANT.
- Throughput: one pixel per cycle while granted. The arbitration overhead is 3 cycles per burst.

## Structure
- Shared package/macros file: `COLOUR_BLACK` (3'b000), the coordinate width (10) and the colour width (3). Burst budgets sit alongside the existing `BRICKDRAWTWO` macro.
- One sub-module is natural: `rr_pick`. It is combinational and takes `req`, `last` and `mask` and returns a one-hot pick and an index. It is instantiated once.

## Test plan
- Single requester: raise `req[1]` with pixel (10,20,3'b101, we=1) for 4 cycles, then drop it. Expect `grant`=5'b00010 one cycle after the request, 4 plots at (10,20,5) starting one cycle later, then `grant`=0 for one cycle.
- Round-robin: hold `req[0]`, `req[1]` and `req[2]` high and drop each 3 cycles after its grant. Expect the grant order 0,1,2,0, with `last` updating each time.
- Priority: with `req[0]` and `req[4]` both raised in the same cycle, expect `grant[4]` first. Raising `req[4]` during the burst of 0 does not preempt; it is granted right after 0's GAP.
- Erase: grant requester 2 with colour 3'b111 and `erase`=1, expecting plotted colour 0. Grant requester 4 with `erase`=1, expecting colour 3'b111.
- Timeout: with MAX_BURST=8, hold `req[3]` high indefinitely. Expect the grant to drop after 8 cycles, `timeout_err`=1, and requester 3 not regranted until its `req` goes low and high again.
- Reset mid-burst: assert `resetn`=0 asynchronously during a grant. Expect `grant`, `writeEn` and `timeout_err` to be 0 immediately, and the first grant after release to go to the lowest pending index ≥0.
